// File: rtl/norm_share_ctrl.sv
// Two-port round-robin sequencer for one shared leading-zero normalizer.
// Ports: clk/rst, req/a/gnt/done/b/sh/zero per port, norm_a/b/sh, busy, err.
module norm_share_ctrl #(
  parameter int W   = 32,
  parameter int SHW = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0,
  input  logic [W-1:0]   a0,
  output logic           gnt0,
  output logic           done0,
  output logic [W-1:0]   b0,
  output logic [SHW-1:0] sh0,
  output logic           zero0,
  input  logic           req1,
  input  logic [W-1:0]   a1,
  output logic           gnt1,
  output logic           done1,
  output logic [W-1:0]   b1,
  output logic [SHW-1:0] sh1,
  output logic           zero1,
  output logic [W-1:0]   norm_a,
  input  logic [W-1:0]   norm_b,
  input  logic [SHW-1:0] norm_sh,
  output logic           busy,
  output logic           err
);

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    RESP
  } state_t;

  state_t         state;
  state_t         state_d;
  logic           rr_ptr;
  logic           owner;
  logic [W-1:0]   opnd;
  logic [W-1:0]   res_b;
  logic [SHW-1:0] res_sh;
  logic           res_z;
  logic           take;
  logic           pick1;

  // pick1: port 1 wins when alone or when the pointer favours it
  always_comb begin
    state_d = state;
    take    = 1'b0;
    pick1   = 1'b0;
    unique case (state)
      IDLE: begin
        if (req0 | req1) begin
          take    = 1'b1;
          pick1   = req1 & (~req0 | rr_ptr);
          state_d = EVAL;
        end
      end
      EVAL:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  assign norm_a = (state == IDLE) ? '0 : opnd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      done0  <= 1'b0;
      done1  <= 1'b0;
      busy   <= 1'b0;
      err    <= 1'b0;
      rr_ptr <= 1'b0;
      owner  <= 1'b0;
      opnd   <= '0;
      res_b  <= '0;
      res_sh <= '0;
      res_z  <= 1'b0;
      b0     <= '0;
      sh0    <= '0;
      zero0  <= 1'b0;
      b1     <= '0;
      sh1    <= '0;
      zero1  <= 1'b0;
    end else begin
      gnt0  <= take & ~pick1;
      gnt1  <= take & pick1;
      done0 <= (state == RESP) & ~owner;
      done1 <= (state == RESP) & owner;
      busy  <= (state_d != IDLE);
      if (take) begin
        opnd   <= pick1 ? a1 : a0;
        owner  <= pick1;
        rr_ptr <= ~pick1;
      end
      if (state == EVAL) begin
        // zero operand bypasses whatever the normalizer reports
        if (opnd == '0) begin
          res_b  <= '0;
          res_sh <= '0;
          res_z  <= 1'b1;
        end else begin
          res_b  <= norm_b;
          res_sh <= norm_sh;
          res_z  <= 1'b0;
          if (!norm_b[W-1]) err <= 1'b1;
        end
      end
      if (state == RESP) begin
        if (owner) begin
          b1    <= res_b;
          sh1   <= res_sh;
          zero1 <= res_z;
        end else begin
          b0    <= res_b;
          sh0   <= res_sh;
          zero0 <= res_z;
        end
      end
    end
  end

endmodule

// File: tb/tb_norm_share_ctrl.sv
// Directed bench for norm_share_ctrl with a behavioural 32-bit normalizer.
// Ports: none; drives the DUT and prints one summary line.
module tb_norm_share_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0;
  logic        req1 = 1'b0;
  logic [31:0] a0 = '0;
  logic [31:0] a1 = '0;
  logic        gnt0, done0, zero0;
  logic        gnt1, done1, zero1;
  logic [31:0] b0, b1;
  logic [4:0]  sh0, sh1;
  logic [31:0] norm_a, norm_b;
  logic [4:0]  norm_sh;
  logic        busy, err;
  logic        stub_en = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  norm_share_ctrl #(.W(32), .SHW(5)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .gnt0(gnt0), .done0(done0),
    .b0(b0), .sh0(sh0), .zero0(zero0),
    .req1(req1), .a1(a1), .gnt1(gnt1), .done1(done1),
    .b1(b1), .sh1(sh1), .zero1(zero1),
    .norm_a(norm_a), .norm_b(norm_b), .norm_sh(norm_sh),
    .busy(busy), .err(err)
  );

  function automatic logic [5:0] clz(input logic [31:0] x);
    for (int i = 31; i >= 0; i--)
      if (x[i]) return 6'(31 - i);
    return 6'd32;
  endfunction

  logic [5:0] lz;
  always_comb begin
    lz      = clz(norm_a);
    norm_b  = norm_a << lz;
    norm_sh = lz[4:0];
    if (stub_en && norm_a == 32'h5) norm_b = 32'h4000_0000;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    req0 = 1'b0;
    req1 = 1'b0;
    rst  = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic op(input bit p, input logic [31:0] a,
                    output int lg, output int ld);
    if (p) begin a1 = a; req1 = 1'b1; end
    else   begin a0 = a; req0 = 1'b1; end
    lg = 0;
    do begin @(negedge clk); lg++; end
    while (!(p ? gnt1 : gnt0) && lg < 10);
    chk("gnt_seen", 32'(p ? gnt1 : gnt0), 32'd1);
    if (p) req1 = 1'b0;
    else   req0 = 1'b0;
    ld = 0;
    do begin @(negedge clk); ld++; end
    while (!(p ? done1 : done0) && ld < 10);
    chk("done_seen", 32'(p ? done1 : done0), 32'd1);
  endtask

  int lg, ld;
  int order[$];
  logic [31:0] exp_b1;
  logic [4:0]  exp_sh1;

  initial begin
    @(negedge clk);
    chk("rst_outs", {gnt0, done0, zero0, gnt1, done1, zero1, busy, err},
        32'd0);
    chk("rst_b0", b0, 32'd0);
    chk("rst_b1", b1, 32'd0);
    chk("rst_sh", {sh0, sh1}, 32'd0);
    chk("rst_norm_a", norm_a, 32'd0);
    rst = 1'b0;

    // single op on port 0, latency check
    op(1'b0, 32'h1, lg, ld);
    chk("t1_lat_g", lg, 1);
    chk("t1_lat_d", ld, 2);
    chk("t1_b0", b0, 32'h8000_0000);
    chk("t1_sh0", sh0, 32'd31);
    chk("t1_zero0", zero0, 32'd0);
    @(negedge clk);
    chk("t1_done_pulse", done0, 32'd0);

    // port 1
    op(1'b1, 32'h00F0_0000, lg, ld);
    chk("t2_b1", b1, 32'hF000_0000);
    chk("t2_sh1", sh1, 32'd8);
    chk("t2_b0_hold", b0, 32'h8000_0000);

    // walking one on port 0
    for (int k = 0; k <= 30; k++) begin
      op(1'b0, 32'h1 << k, lg, ld);
      chk("t3_b0", b0, 32'h8000_0000);
      chk("t3_sh0", sh0, 32'(31 - k));
    end
    chk("t3_err", err, 32'd0);
    chk("t3_b1_hold", b1, 32'hF000_0000);

    // zero operand on port 1
    op(1'b1, 32'h0, lg, ld);
    chk("t5_b1", b1, 32'd0);
    chk("t5_sh1", sh1, 32'd0);
    chk("t5_zero1", zero1, 32'd1);
    chk("t5_err", err, 32'd0);
    chk("t5_sh0_hold", sh0, 32'd1);

    // both held continuously after reset
    do_reset();
    exp_b1  = '0;
    exp_sh1 = '0;
    a0 = 32'h0001_0000;
    a1 = 32'h0000_0300;
    req0 = 1'b1;
    req1 = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (gnt0) order.push_back(0);
      if (gnt1) order.push_back(1);
      if (done1) begin
        exp_b1  = 32'hC000_0000;
        exp_sh1 = 5'd22;
      end
      chk("t4_b1", b1, exp_b1);
      chk("t4_sh1", sh1, 32'(exp_sh1));
      chk("t4_gnt_excl", 32'(gnt0 & gnt1), 32'd0);
      chk("t4_done_excl", 32'(done0 & done1), 32'd0);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (4) @(negedge clk);
    chk("t4_ngrants", order.size(), 4);
    while (order.size() < 4) order.push_back(-1);
    chk("t4_g0", order[0], 0);
    chk("t4_g1", order[1], 1);
    chk("t4_g2", order[2], 0);
    chk("t4_g3", order[3], 1);
    chk("t4_b0", b0, 32'h8000_0000);
    chk("t4_sh0", sh0, 32'd15);

    // reset during EVAL
    a0 = 32'h0000_0123;
    req0 = 1'b1;
    @(negedge clk);
    chk("t6_gnt", gnt0, 32'd1);
    req0 = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6_outs", {gnt0, done0, gnt1, done1, busy, err}, 32'd0);
    chk("t6_b0", b0, 32'd0);
    chk("t6_norm_a", norm_a, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t6_no_done", 32'(done0 | done1), 32'd0);
    end
    op(1'b1, 32'h8000_0000, lg, ld);
    chk("t6_lat_d", ld, 2);
    chk("t6_b1", b1, 32'h8000_0000);
    chk("t6_sh1", sh1, 32'd0);

    // broken normalizer sets sticky err
    stub_en = 1'b1;
    op(1'b0, 32'h5, lg, ld);
    chk("t7_b0", b0, 32'h4000_0000);
    chk("t7_sh0", sh0, 32'd29);
    chk("t7_err", err, 32'd1);
    stub_en = 1'b0;
    op(1'b0, 32'h5, lg, ld);
    chk("t7_b0_ok", b0, 32'hA000_0000);
    chk("t7_err_sticky", err, 32'd1);
    do_reset();
    chk("t7_err_rst", err, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
